display_mode: RTL and testbench

DISPLAY_MODE -- requirements
Module: display_mode

---
 rtl/display_mode_pkg.sv | 54 +++++
 rtl/display_mode_bin2dec_serial.sv | 61 ++++++
 rtl/display_mode.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_display_mode.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_mode_pkg.sv
// -----------------------------------------------------------------------------
// display_mode_pkg
// Shared constants for the matrix display path: default element and BRAM
// address widths, the matrix-manager error codes, the display FSM state
// encodings, and small ASCII helpers for printing matrix dimensions.
// No ports (package).
// -----------------------------------------------------------------------------
package display_mode_pkg;

    // Default data-path widths shared with the matrix manager and BRAM.
    localparam int ELEMENT_WIDTH   = 8;
    localparam int BRAM_ADDR_WIDTH = 8;

    // Matrix subsystem error codes. ERR_SLOT_EMPTY is reported by the
    // display path when the requested slot has no committed matrix.
    localparam logic [3:0] ERR_NONE         = 4'h0;
    localparam logic [3:0] ERR_DIM_MISMATCH = 4'h1;
    localparam logic [3:0] ERR_BAD_SLOT     = 4'h2;
    localparam logic [3:0] ERR_OVERFLOW     = 4'h3;
    localparam logic [3:0] ERR_SLOT_EMPTY   = 4'h4;

    // Display FSM states (also exported on sub_state).
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_QUERY    = 4'd1;
    localparam logic [3:0] ST_CHECK    = 4'd2;
    localparam logic [3:0] ST_HEADER   = 4'd3;
    localparam logic [3:0] ST_READ     = 4'd4;
    localparam logic [3:0] ST_WAIT_RD  = 4'd5;
    localparam logic [3:0] ST_CONVERT  = 4'd6;
    localparam logic [3:0] ST_SEND_DIG = 4'd7;
    localparam logic [3:0] ST_SEND_SEP = 4'd8;
    localparam logic [3:0] ST_SEND_EOL = 4'd9;
    localparam logic [3:0] ST_DONE     = 4'd10;
    localparam logic [3:0] ST_ERROR    = 4'd11;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // ASCII digits of a dimension (0..15), first character in the low byte.
    function automatic logic [15:0] dim_ascii(input logic [3:0] v);
        if (v >= 4'd10)
            return {ASCII_ZERO + 8'(v - 4'd10), ASCII_ZERO + 8'd1};
        else
            return {8'h00, ASCII_ZERO + 8'(v)};
    endfunction

    // Number of characters dim_ascii produces for v.
    function automatic logic [2:0] dim_len(input logic [3:0] v);
        return (v >= 4'd10) ? 3'd2 : 3'd1;
    endfunction

endpackage

// File: rtl/display_mode_bin2dec_serial.sv
// -----------------------------------------------------------------------------
// bin2dec_serial
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3, 8 cycles).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           accepted only while ready is high; loads bin
//   bin[7:0]        value to convert
//   ready           high when idle; bcd/ndig valid once ready returns high
//   bcd[11:0]       hundreds/tens/units digits
//   ndig[1:0]       number of significant digits (1..3)
// -----------------------------------------------------------------------------
module bin2dec_serial (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        ready,
    output logic [11:0] bcd,
    output logic [1:0]  ndig
);

    logic [7:0]  r_shift;
    logic [11:0] r_bcd;
    logic [2:0]  r_cnt;
    logic        r_busy;
    logic [11:0] w_adj;

    // Add 3 to every BCD digit that is 5 or more before the next shift.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_adj
            assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                      r_bcd[gi*4 +: 4] + 4'd3 :
                                      r_bcd[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else if (start && !r_busy) begin
            r_shift <= bin;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            {r_bcd, r_shift} <= {w_adj[10:0], r_shift, 1'b0};
            r_cnt            <= r_cnt + 3'd1;
            if (r_cnt == 3'd7)
                r_busy <= 1'b0;
        end
    end

    assign ready = !r_busy;
    assign bcd   = r_bcd;
    assign ndig  = (r_bcd[11:8] != 4'd0) ? 2'd3 :
                   (r_bcd[7:4]  != 4'd0) ? 2'd2 : 2'd1;

endmodule

// File: rtl/display_mode.sv
// -----------------------------------------------------------------------------
// display_mode
// Prints a stored matrix over the UART as ASCII: header "<m> <n>\r\n", then
// each row as space-separated decimal elements terminated by "\r\n".
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   mode_active                      block enable; low forces IDLE
//   start, sel_slot[3:0]             print request for a matrix slot
//   query_req, query_slot[3:0]       lookup request to the matrix manager
//   query_valid, query_m, query_n,
//   query_addr[ADDR_WIDTH-1:0]       lookup response (sampled in CHECK)
//   mem_rd_en, mem_rd_addr,
//   mem_rd_data[ELEMENT_WIDTH-1:0]   BRAM read port, 1-cycle latency
//   tx_data[7:0], tx_start, tx_busy  UART transmitter handshake
//   done                             one-cycle pulse at end of stream
//   error_code[3:0], sub_state[3:0]  status
// -----------------------------------------------------------------------------
module display_mode #(
    parameter int ELEMENT_WIDTH = display_mode_pkg::ELEMENT_WIDTH,
    parameter int ADDR_WIDTH    = display_mode_pkg::BRAM_ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode_active,
    input  logic                     start,
    input  logic [3:0]               sel_slot,
    output logic                     query_req,
    output logic [3:0]               query_slot,
    input  logic                     query_valid,
    input  logic [3:0]               query_m,
    input  logic [3:0]               query_n,
    input  logic [ADDR_WIDTH-1:0]    query_addr,
    output logic                     mem_rd_en,
    output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
    input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic                     done,
    output logic [3:0]               error_code,
    output logic [3:0]               sub_state
);

    import display_mode_pkg::*;

    logic [3:0]            r_state;
    logic                  r_query_req;
    logic [3:0]            r_query_slot;
    logic [3:0]            r_m;
    logic [3:0]            r_n;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [3:0]            r_row;
    logic [3:0]            r_col;
    logic [7:0]            r_elem;
    logic [55:0]           r_hdr;        // pending header bytes, next in [7:0]
    logic [2:0]            r_hdr_cnt;
    logic [11:0]           r_digits;
    logic [1:0]            r_dig_left;   // digits still to send, MS first
    logic                  r_cv_launched;
    logic                  r_eol_lf;     // CR already sent, LF next
    logic [1:0]            r_gap;        // post-pulse hold-off counter
    logic                  r_tx_start;
    logic [7:0]            r_tx_data;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_done;
    logic [3:0]            r_err;

    logic                  w_send;
    logic [7:0]            w_send_byte;
    logic [3:0]            w_digit;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [55:0]           w_hdr;
    logic [2:0]            w_hdr_len;
    logic                  w_b2d_start;
    logic                  w_b2d_ready;
    logic [11:0]           w_bcd;
    logic [1:0]            w_ndig;

    // Element address wraps naturally at the ADDR_WIDTH boundary.
    assign w_addr_next = r_base + ADDR_WIDTH'(r_elem);

    // Header bytes assembled right-to-left so the first character ends up
    // in the low byte: "<m>" " " "<n>" CR LF.
    always_comb begin
        logic [55:0] tail;
        tail      = 56'h0A0D << (8 * dim_len(query_n));
        tail      = tail | {40'b0, dim_ascii(query_n)};
        tail      = (tail << 8) | {48'b0, ASCII_SPACE};
        w_hdr     = (tail << (8 * dim_len(query_m))) | {40'b0, dim_ascii(query_m)};
        w_hdr_len = dim_len(query_m) + dim_len(query_n) + 3'd3;
    end

    always_comb begin
        w_digit = r_digits[3:0];
        case (r_dig_left)
            2'd3:    w_digit = r_digits[11:8];
            2'd2:    w_digit = r_digits[7:4];
            default: w_digit = r_digits[3:0];
        endcase
    end

    always_comb begin
        w_send_byte = 8'h00;
        case (r_state)
            ST_HEADER:   w_send_byte = r_hdr[7:0];
            ST_SEND_DIG: w_send_byte = ASCII_ZERO + {4'b0, w_digit};
            ST_SEND_SEP: w_send_byte = ASCII_SPACE;
            ST_SEND_EOL: w_send_byte = r_eol_lf ? ASCII_LF : ASCII_CR;
            default:     w_send_byte = 8'h00;
        endcase
    end

    // A byte goes out only from a sending state, with the hold-off expired
    // and the transmitter idle.
    assign w_send = mode_active && (r_gap == 2'd0) && !tx_busy &&
                    ((r_state == ST_HEADER)   || (r_state == ST_SEND_DIG) ||
                     (r_state == ST_SEND_SEP) || (r_state == ST_SEND_EOL));

    // The converter is launched from the BRAM output register, which holds
    // the element until the next read.
    assign w_b2d_start = mode_active && (r_state == ST_CONVERT) &&
                         !r_cv_launched && w_b2d_ready;

    bin2dec_serial u_bin2dec (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_b2d_start),
        .bin   (8'(mem_rd_data)),
        .ready (w_b2d_ready),
        .bcd   (w_bcd),
        .ndig  (w_ndig)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_query_req   <= 1'b0;
            r_query_slot  <= '0;
            r_m           <= '0;
            r_n           <= '0;
            r_base        <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_elem        <= '0;
            r_hdr         <= '0;
            r_hdr_cnt     <= '0;
            r_digits      <= '0;
            r_dig_left    <= '0;
            r_cv_launched <= 1'b0;
            r_eol_lf      <= 1'b0;
            r_gap         <= '0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= '0;
            r_rd_en       <= 1'b0;
            r_rd_addr     <= '0;
            r_done        <= 1'b0;
            r_err         <= ERR_NONE;
        end else if (!mode_active) begin
            // Abort: strobes and counters cleared; tx_data is left alone so a
            // byte already handed to the UART stays intact.
            r_state       <= ST_IDLE;
            r_query_req   <= 1'b0;
            r_row         <= '0;
            r_col         <= '0;
            r_elem        <= '0;
            r_hdr_cnt     <= '0;
            r_dig_left    <= '0;
            r_cv_launched <= 1'b0;
            r_eol_lf      <= 1'b0;
            r_gap         <= '0;
            r_tx_start    <= 1'b0;
            r_rd_en       <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= ERR_NONE;
        end else begin
            r_tx_start  <= 1'b0;
            r_rd_en     <= 1'b0;
            r_done      <= 1'b0;
            r_query_req <= 1'b0;

            if (w_send) begin
                r_tx_start <= 1'b1;
                r_tx_data  <= w_send_byte;
                r_gap      <= 2'd2;
            end else if (r_gap != 2'd0) begin
                r_gap <= r_gap - 2'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_query_slot <= sel_slot;
                        r_err        <= ERR_NONE;
                        r_query_req  <= 1'b1;
                        r_state      <= ST_QUERY;
                    end
                end
                ST_QUERY: r_state <= ST_CHECK;
                ST_CHECK: begin
                    if (!query_valid || (query_m == 4'd0) || (query_n == 4'd0)) begin
                        r_err   <= ERR_SLOT_EMPTY;
                        r_state <= ST_ERROR;
                    end else begin
                        r_m       <= query_m;
                        r_n       <= query_n;
                        r_base    <= query_addr;
                        r_hdr     <= w_hdr;
                        r_hdr_cnt <= w_hdr_len;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_elem    <= '0;
                        r_state   <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (w_send) begin
                        r_hdr     <= r_hdr >> 8;
                        r_hdr_cnt <= r_hdr_cnt - 3'd1;
                        if (r_hdr_cnt == 3'd1)
                            r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_rd_en       <= 1'b1;
                    r_rd_addr     <= w_addr_next;
                    r_cv_launched <= 1'b0;
                    r_state       <= ST_WAIT_RD;
                end
                ST_WAIT_RD: r_state <= ST_CONVERT;
                ST_CONVERT: begin
                    if (!r_cv_launched) begin
                        if (w_b2d_ready)
                            r_cv_launched <= 1'b1;
                    end else if (w_b2d_ready) begin
                        r_digits   <= w_bcd;
                        r_dig_left <= w_ndig;
                        r_state    <= ST_SEND_DIG;
                    end
                end
                ST_SEND_DIG: begin
                    if (w_send) begin
                        r_dig_left <= r_dig_left - 2'd1;
                        if (r_dig_left == 2'd1) begin
                            r_eol_lf <= 1'b0;
                            r_state  <= (r_col == r_n - 4'd1) ? ST_SEND_EOL : ST_SEND_SEP;
                        end
                    end
                end
                ST_SEND_SEP: begin
                    if (w_send) begin
                        r_col   <= r_col + 4'd1;
                        r_elem  <= r_elem + 8'd1;
                        r_state <= ST_READ;
                    end
                end
                ST_SEND_EOL: begin
                    if (w_send) begin
                        if (!r_eol_lf) begin
                            r_eol_lf <= 1'b1;
                        end else begin
                            r_eol_lf <= 1'b0;
                            if (r_row == r_m - 4'd1) begin
                                r_done  <= 1'b1;
                                r_state <= ST_DONE;
                            end else begin
                                r_row   <= r_row + 4'd1;
                                r_col   <= '0;
                                r_elem  <= r_elem + 8'd1;
                                r_state <= ST_READ;
                            end
                        end
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                ST_ERROR: r_state <= ST_ERROR;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign query_req   = r_query_req;
    assign query_slot  = r_query_slot;
    assign mem_rd_en   = r_rd_en;
    assign mem_rd_addr = r_rd_addr;
    assign tx_data     = r_tx_data;
    assign tx_start    = r_tx_start;
    assign done        = r_done;
    assign error_code  = r_err;
    assign sub_state   = r_state;

endmodule

// File: tb/tb_display_mode.sv
// -----------------------------------------------------------------------------
// tb_display_mode
// Directed bench for display_mode: BRAM and matrix-manager models, a UART
// model with busy time and an optional stall, and hand-written expected
// byte streams.
// -----------------------------------------------------------------------------
module tb_display_mode;

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_ERROR      = 4'd11;
    localparam logic [3:0] E_NONE       = 4'd0;
    localparam logic [3:0] E_SLOT_EMPTY = 4'd4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode_active;
    logic       start;
    logic [3:0] sel_slot;
    logic       query_req;
    logic [3:0] query_slot;
    logic       query_valid;
    logic [3:0] query_m;
    logic [3:0] query_n;
    logic [7:0] query_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rd_addr;
    logic [7:0] mem_rd_data = 8'h00;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       done;
    logic [3:0] error_code;
    logic [3:0] sub_state;

    always #5 clk = ~clk;

    display_mode dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode_active (mode_active),
        .start       (start),
        .sel_slot    (sel_slot),
        .query_req   (query_req),
        .query_slot  (query_slot),
        .query_valid (query_valid),
        .query_m     (query_m),
        .query_n     (query_n),
        .query_addr  (query_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .done        (done),
        .error_code  (error_code),
        .sub_state   (sub_state)
    );

    // Matrix manager model: slot table looked up by query_slot.
    logic       slot_valid [16];
    logic [3:0] slot_m     [16];
    logic [3:0] slot_n     [16];
    logic [7:0] slot_addr  [16];
    logic [7:0] mem        [256];

    assign query_valid = slot_valid[query_slot];
    assign query_m     = slot_m[query_slot];
    assign query_n     = slot_n[query_slot];
    assign query_addr  = slot_addr[query_slot];

    always @(posedge clk)
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    // UART model and monitors.
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_tx_cyc = -100;
    int         busy_cnt = 0;
    int         viol = 0;
    int         done_cnt = 0;
    int         qreq_cnt = 0;
    int         tx_total = 0;
    logic       stall = 1'b0;
    logic       busy_at_edge = 1'b0;
    logic [7:0] last_tx_data = 8'h00;
    logic [7:0] rx_q[$];
    logic [7:0] rd_q[$];

    assign tx_busy = stall | (busy_cnt != 0);

    always @(posedge clk) busy_at_edge <= tx_busy;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (tx_start) tx_total = tx_total + 1;
        if (!rst_n) begin
            last_tx_data = 8'h00;
            busy_cnt     = 0;
        end else begin
            if (tx_start) begin
                if (busy_at_edge) viol = viol + 1;
                if (cyc - last_tx_cyc < 3) viol = viol + 1;
                rx_q.push_back(tx_data);
                last_tx_cyc  = cyc;
                last_tx_data = tx_data;
                busy_cnt     = 4;
            end else begin
                if (tx_data != last_tx_data) viol = viol + 1;
                if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
            end
            if (mem_rd_en) rd_q.push_back(mem_rd_addr);
            if (done) done_cnt = done_cnt + 1;
            if (query_req) qreq_cnt = qreq_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        rx_q.delete();
        rd_q.delete();
        done_cnt = 0;
        qreq_cnt = 0;
    endtask

    task automatic pulse_start(input logic [3:0] slot);
        sel_slot = slot;
        start    = 1'b1;
        tick(1);
        start    = 1'b0;
    endtask

    task automatic wait_end(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (done_cnt > 0 || sub_state == S_ERROR) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        tick(3);
    endtask

    task automatic wait_bytes(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (rx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    // Expected stream written with '|' standing for CR LF.
    task automatic expect_stream(input string tag, input string s);
        logic [7:0] exp_q[$];
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "|") begin
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end else begin
                exp_q.push_back(s[i]);
            end
        end
        check_eq({tag, "_len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check_eq($sformatf("%s_byte%0d", tag, i), {24'b0, rx_q[i]}, {24'b0, exp_q[i]});
    endtask

    task automatic expect_addrs(input string tag, input logic [7:0] base, input int cnt);
        logic [7:0] a;
        check_eq({tag, "_rdcnt"}, rd_q.size(), cnt);
        a = base;
        for (int i = 0; i < cnt && i < rd_q.size(); i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), {24'b0, rd_q[i]}, {24'b0, a});
            a = a + 8'd1;
        end
    endtask

    task automatic check_idle_strobes(input string tag);
        check_eq({tag, "_state"}, sub_state, S_IDLE);
        check_eq({tag, "_tx_start"}, tx_start, 0);
        check_eq({tag, "_rd_en"}, mem_rd_en, 0);
        check_eq({tag, "_qreq"}, query_req, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_err"}, error_code, E_NONE);
    endtask

    initial begin
        bit ok;
        int n0;

        rst_n = 1'b0; mode_active = 1'b0; start = 1'b0; sel_slot = 4'd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) begin
            slot_valid[i] = 1'b0; slot_m[i] = 4'd0; slot_n[i] = 4'd0; slot_addr[i] = 8'd0;
        end
        slot_valid[0] = 1; slot_m[0] = 2;  slot_n[0] = 3; slot_addr[0] = 8'd16;
        for (int i = 0; i < 6; i++) mem[16+i] = 8'(i + 1);
        slot_valid[1] = 1; slot_m[1] = 1;  slot_n[1] = 3; slot_addr[1] = 8'd40;
        mem[40] = 8'd0; mem[41] = 8'd10; mem[42] = 8'd255;
        slot_valid[3] = 1; slot_m[3] = 0;  slot_n[3] = 2; slot_addr[3] = 8'd0;
        slot_valid[4] = 1; slot_m[4] = 2;  slot_n[4] = 2; slot_addr[4] = 8'd254;
        mem[254] = 8'd7; mem[255] = 8'd8; mem[0] = 8'd9; mem[1] = 8'd12;
        slot_valid[5] = 1; slot_m[5] = 12; slot_n[5] = 1; slot_addr[5] = 8'd100;
        for (int i = 0; i < 12; i++) mem[100+i] = 8'(i * 20);

        // Reset state
        tick(3);
        check_idle_strobes("rst");
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_rd_addr", mem_rd_addr, 0);
        check_eq("rst_qslot", query_slot, 0);
        $display("[tb] reset values checked");
        rst_n = 1'b1; mode_active = 1'b1;
        tick(2);

        // 2x3 matrix
        clear_logs(); pulse_start(4'd0); wait_end(ok);
        check_eq("t1_finish", ok, 1);
        expect_stream("t1", "2 3|1 2 3|4 5 6|");
        expect_addrs("t1", 8'd16, 6);
        check_eq("t1_done", done_cnt, 1);
        check_eq("t1_qreq_cycles", qreq_cnt, 1);
        check_eq("t1_end_state", sub_state, S_IDLE);
        $display("[tb] 2x3 slot0: %0d bytes, %0d reads", rx_q.size(), rd_q.size());

        // 1x3 with 0, 10, 255
        clear_logs(); pulse_start(4'd1); wait_end(ok);
        check_eq("t2_finish", ok, 1);
        expect_stream("t2", "1 3|0 10 255|");
        expect_addrs("t2", 8'd40, 3);
        check_eq("t2_done", done_cnt, 1);
        $display("[tb] 1x3 slot1: %0d bytes, %0d reads", rx_q.size(), rd_q.size());

        // Empty slot
        clear_logs(); pulse_start(4'd2); wait_end(ok);
        check_eq("t3_finish", ok, 1);
        check_eq("t3_err", error_code, E_SLOT_EMPTY);
        check_eq("t3_state", sub_state, S_ERROR);
        check_eq("t3_tx", rx_q.size(), 0);
        check_eq("t3_rd", rd_q.size(), 0);
        pulse_start(4'd0); tick(50);
        check_eq("t3_start_ignored", sub_state, S_ERROR);
        check_eq("t3_tx_after", rx_q.size(), 0);
        mode_active = 1'b0; tick(1);
        check_eq("t3_exit_state", sub_state, S_IDLE);
        check_eq("t3_exit_err", error_code, E_NONE);
        mode_active = 1'b1; tick(1);
        $display("[tb] empty slot2: err=%0d", E_SLOT_EMPTY);

        // Valid slot with m=0
        clear_logs(); pulse_start(4'd3); wait_end(ok);
        check_eq("t3b_err", error_code, E_SLOT_EMPTY);
        check_eq("t3b_tx", rx_q.size(), 0);
        mode_active = 1'b0; tick(1); mode_active = 1'b1; tick(1);
        $display("[tb] zero-row slot3 rejected");

        // 12x1: two-digit header, no separators
        clear_logs(); pulse_start(4'd5); wait_end(ok);
        check_eq("t4_finish", ok, 1);
        expect_stream("t4", "12 1|0|20|40|60|80|100|120|140|160|180|200|220|");
        $display("[tb] 12x1 slot5: %0d bytes", rx_q.size());

        // UART stall of 1000 cycles mid-stream
        clear_logs(); pulse_start(4'd0);
        wait_bytes(5, ok);
        check_eq("t5_reach5", ok, 1);
        stall = 1'b1; tick(1);
        n0 = rx_q.size();
        tick(1000);
        check_eq("t5_no_tx_in_stall", rx_q.size(), n0);
        stall = 1'b0;
        wait_end(ok);
        check_eq("t5_finish", ok, 1);
        expect_stream("t5", "2 3|1 2 3|4 5 6|");
        $display("[tb] stall test: %0d bytes", rx_q.size());

        // mode_active dropped after byte 7
        clear_logs(); pulse_start(4'd0);
        wait_bytes(7, ok);
        check_eq("t6_reach7", ok, 1);
        mode_active = 1'b0; tick(1);
        check_idle_strobes("t6");
        tick(5);
        check_eq("t6_no_more_bytes", rx_q.size(), 7);
        mode_active = 1'b1; tick(10);
        clear_logs(); pulse_start(4'd0); wait_end(ok);
        check_eq("t6_finish", ok, 1);
        expect_stream("t6r", "2 3|1 2 3|4 5 6|");
        $display("[tb] abort and reprint: %0d bytes", rx_q.size());

        // Address wrap
        clear_logs(); pulse_start(4'd4); wait_end(ok);
        check_eq("t7_finish", ok, 1);
        expect_stream("t7", "2 2|7 8|9 12|");
        expect_addrs("t7", 8'd254, 4);
        $display("[tb] wrap slot4: %0d bytes", rx_q.size());

        // Reset mid-stream
        clear_logs(); pulse_start(4'd1);
        wait_bytes(4, ok);
        check_eq("t8_reach4", ok, 1);
        rst_n = 1'b0; #1;
        check_eq("t8_state", sub_state, S_IDLE);
        check_eq("t8_tx_start", tx_start, 0);
        check_eq("t8_tx_data", tx_data, 0);
        check_eq("t8_rd_en", mem_rd_en, 0);
        check_eq("t8_rd_addr", mem_rd_addr, 0);
        check_eq("t8_qreq", query_req, 0);
        check_eq("t8_qslot", query_slot, 0);
        check_eq("t8_done", done, 0);
        check_eq("t8_err", error_code, E_NONE);
        n0 = tx_total;
        tick(20);
        check_eq("t8_no_tx_in_reset", tx_total, n0);
        rst_n = 1'b1; tick(2);
        clear_logs(); pulse_start(4'd1); wait_end(ok);
        check_eq("t8_finish", ok, 1);
        expect_stream("t8r", "1 3|0 10 255|");
        $display("[tb] reset mid-stream and reprint: %0d bytes", rx_q.size());

        check_eq("proto_violations", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
